// File: rtl/regfile_write_arbiter.sv
// Merges ALU and load writebacks into the single register-file write port.
// Each source is buffered in its own FIFO; the mem source is forced through after STARVE_LIMIT lost cycles.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         aluValid,
  input  logic [ADDR_WIDTH-1:0]        aluRegister,
  input  logic [DATA_WIDTH-1:0]        aluData,
  output logic                         aluReady,
  input  logic                         memValid,
  input  logic [ADDR_WIDTH-1:0]        memRegister,
  input  logic [DATA_WIDTH-1:0]        memData,
  output logic                         memReady,
  output logic [ADDR_WIDTH-1:0]        writeRegister,
  output logic [DATA_WIDTH-1:0]        writeData,
  output logic                         regWrite,
  output logic [(2**ADDR_WIDTH)-1:0]   pendingMask
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int SW  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int ALU = 0;
  localparam int MEM = 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE = 2'd0, ALU_GRANT = 2'd1, MEM_GRANT = 2'd2} state_t;

  logic [ADDR_WIDTH-1:0] ent_reg_q [2][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] ent_dat_q [2][FIFO_DEPTH];
  logic [PW-1:0]         wp_q [2];
  logic [PW-1:0]         rp_q [2];
  logic [CW-1:0]         cnt_q [2];
  logic [CW-1:0]         cnt_d [2];
  logic [SW-1:0]         starve_q, starve_d;
  state_t                state_q, state_d;
  logic                  rdy_q;
  logic                  push [2];
  logic                  pop  [2];
  logic [ADDR_WIDTH-1:0] in_reg [2];
  logic [DATA_WIDTH-1:0] in_dat [2];
  logic                  hsrc;
  logic [ADDR_WIDTH-1:0] head_reg;
  logic [DATA_WIDTH-1:0] head_dat;
  logic [PW-1:0]         off;

  assign in_reg[ALU] = aluRegister;
  assign in_reg[MEM] = memRegister;
  assign in_dat[ALU] = aluData;
  assign in_dat[MEM] = memData;

  // Ready depends on registered occupancy only; a pop in the same cycle earns no credit.
  assign aluReady  = rdy_q & (cnt_q[ALU] != FULL_CNT);
  assign memReady  = rdy_q & (cnt_q[MEM] != FULL_CNT);
  assign push[ALU] = aluValid & aluReady & ~flush;
  assign push[MEM] = memValid & memReady & ~flush;
  assign pop[ALU]  = ~flush & (state_q == ALU_GRANT);
  assign pop[MEM]  = ~flush & (state_q == MEM_GRANT);

  assign hsrc     = (state_q == MEM_GRANT);
  assign head_reg = ent_reg_q[hsrc][rp_q[hsrc]];
  assign head_dat = ent_dat_q[hsrc][rp_q[hsrc]];

  // The grant for the coming cycle is chosen from next-cycle occupancy and starve count,
  // so the state register always names the source popped in the current cycle.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      if (flush) cnt_d[s] = '0;
      else       cnt_d[s] = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
    end
    if (flush || (cnt_q[MEM] == '0) || pop[MEM]) starve_d = '0;
    else if (starve_q == STARVE_MAX)              starve_d = starve_q;
    else                                          starve_d = starve_q + 1'b1;
    if ((cnt_d[MEM] != '0) && (starve_d == STARVE_MAX)) state_d = MEM_GRANT;
    else if (cnt_d[ALU] != '0)                          state_d = ALU_GRANT;
    else if (cnt_d[MEM] != '0)                          state_d = MEM_GRANT;
    else                                                state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q         <= 1'b0;
      state_q       <= IDLE;
      starve_q      <= '0;
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
      for (int s = 0; s < 2; s++) begin
        wp_q[s]  <= '0;
        rp_q[s]  <= '0;
        cnt_q[s] <= '0;
      end
    end else begin
      rdy_q    <= 1'b1;
      state_q  <= state_d;
      starve_q <= starve_d;
      for (int s = 0; s < 2; s++) begin
        cnt_q[s] <= cnt_d[s];
        if (flush) begin
          wp_q[s] <= '0;
          rp_q[s] <= '0;
        end else begin
          if (push[s]) wp_q[s] <= wp_q[s] + 1'b1;
          if (pop[s])  rp_q[s] <= rp_q[s] + 1'b1;
        end
      end
      regWrite <= 1'b0;
      if (pop[ALU] | pop[MEM]) begin
        writeRegister <= head_reg;
        writeData     <= head_dat;
        regWrite      <= (head_reg != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        ent_reg_q[s][wp_q[s]] <= in_reg[s];
        ent_dat_q[s][wp_q[s]] <= in_dat[s];
      end
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    pendingMask = '0;
    off         = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        off = PW'(i) - rp_q[s];
        if (CW'(off) < cnt_q[s]) pendingMask[ent_reg_q[s][i]] = 1'b1;
      end
    end
    if (regWrite) pendingMask[writeRegister] = 1'b1;
    pendingMask[0] = 1'b0;
  end

endmodule
